clk_div_monitor: RTL and testbench

//   Single-clock checker downstream of the divide-by-N clock generators. Samples a divided

---
 rtl/clk_div_monitor.sv | 151 +++++++++++++++
 tb/tb_clk_div_monitor.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_monitor.sv
// rtl/clk_div_monitor.sv - period/high-time checker and lock detector for a divided clock
//
// Samples a divided clock on posedge clk, measures its period and high time in
// clk cycles, declares lock after LOCK_COUNT consecutive periods equal to
// exp_period, and flags period mismatches and a stuck input.
//
// Ports:
//   clk          input clock, all logic on its rising edge
//   reset        asynchronous active-low reset
//   enable       1 = run; 0 = return to IDLE and clear counters
//   div_in       divided clock under test
//   exp_period   expected period in clk cycles, sampled at each rise
//   period_meas  last complete period in cycles
//   high_meas    last complete high time in cycles
//   rise_pulse   one-cycle pulse per detected rising edge of div_in
//   locked       high while in LOCKED
//   err_period   one-cycle pulse on each period mismatch
//   err_stuck    one-cycle pulse when no rise is seen for TIMEOUT cycles
module clk_div_monitor #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8,
  parameter int LOCK_COUNT  = 4,
  parameter int TIMEOUT     = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             div_in,
  input  logic [CNT_W-1:0] exp_period,
  output logic [CNT_W-1:0] period_meas,
  output logic [CNT_W-1:0] high_meas,
  output logic             rise_pulse,
  output logic             locked,
  output logic             err_period,
  output logic             err_stuck
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ACQUIRE = 2'd1;
  localparam logic [1:0] MEASURE = 2'd2;
  localparam logic [1:0] LOCKED  = 2'd3;

  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [3:0]       LOCK_C    = 4'(LOCK_COUNT);

  logic             div_s;
  logic             div_d;
  logic             rise;
  logic             fall;
  logic             period_ok;
  logic [1:0]       state;
  logic [3:0]       good_cnt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] hcnt;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign div_s = div_in;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q;
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          sync_q <= '0;
        end else begin
          sync_q[0] <= div_in;
          for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
          end
        end
      end
      assign div_s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  assign rise = div_s & ~div_d;
  assign fall = ~div_s & div_d;
  // Periods of 0 or 1 are not measurable, so such an expectation never matches.
  assign period_ok = (cnt == exp_period) && (exp_period[CNT_W-1:1] != '0);
  assign locked = (state == LOCKED);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_d       <= 1'b0;
      state       <= IDLE;
      good_cnt    <= '0;
      cnt         <= '0;
      hcnt        <= '0;
      period_meas <= '0;
      high_meas   <= '0;
      rise_pulse  <= 1'b0;
      err_period  <= 1'b0;
      err_stuck   <= 1'b0;
    end else begin
      div_d      <= div_s;
      rise_pulse <= 1'b0;
      err_period <= 1'b0;
      err_stuck  <= 1'b0;
      if (!enable || state == IDLE) begin
        // Measurements are kept across an enable drop; only the live counters clear.
        state    <= enable ? ACQUIRE : IDLE;
        cnt      <= '0;
        hcnt     <= '0;
        good_cnt <= '0;
        rise_pulse <= enable & rise;
      end else begin
        rise_pulse <= rise;

        if (rise) begin
          hcnt <= CNT_ONE;
        end else if (div_s && hcnt != CNT_MAX) begin
          hcnt <= hcnt + CNT_ONE;
        end
        // The high phase seen in ACQUIRE may be partial, so it is not captured.
        if (fall && state != ACQUIRE) begin
          high_meas <= hcnt;
        end

        // A rise takes priority over a coincident timeout.
        if (rise) begin
          cnt <= CNT_ONE;
          if (state == ACQUIRE) begin
            state    <= MEASURE;
            good_cnt <= '0;
          end else begin
            period_meas <= cnt;
            if (!period_ok) begin
              state      <= MEASURE;
              good_cnt   <= '0;
              err_period <= 1'b1;
            end else if (state == MEASURE) begin
              good_cnt <= good_cnt + 4'd1;
              if (good_cnt + 4'd1 == LOCK_C) begin
                state <= LOCKED;
              end
            end
          end
        end else if (cnt == TIMEOUT_C) begin
          err_stuck <= 1'b1;
          cnt       <= '0;
          good_cnt  <= '0;
          state     <= ACQUIRE;
        end else if (cnt != CNT_MAX) begin
          cnt <= cnt + CNT_ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_clk_div_monitor.sv
// tb/tb_clk_div_monitor.sv - self-checking bench for clk_div_monitor
module tb_clk_div_monitor;

  localparam int CNT_W      = 8;
  localparam int LOCK_COUNT = 4;
  localparam int TIMEOUT    = 255;

  logic             clk = 1'b0;
  logic             reset;
  logic             enable;
  logic             div_in;
  logic [CNT_W-1:0] exp_period;
  logic [CNT_W-1:0] period_meas;
  logic [CNT_W-1:0] high_meas;
  logic             rise_pulse;
  logic             locked;
  logic             err_period;
  logic             err_stuck;

  always #5 clk = ~clk;

  clk_div_monitor #(
    .SYNC_STAGES(2),
    .CNT_W(CNT_W),
    .LOCK_COUNT(LOCK_COUNT),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .div_in(div_in),
    .exp_period(exp_period),
    .period_meas(period_meas),
    .high_meas(high_meas),
    .rise_pulse(rise_pulse),
    .locked(locked),
    .err_period(err_period),
    .err_stuck(err_stuck)
  );

  typedef struct {
    bit chk;
    int period;
    int high;
    bit err;
    bit lock;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_assert  = 0;
  int   n_fail    = 0;
  int   stuck_cnt = 0;
  int   err_cnt   = 0;

  // Reference model of the monitor as seen from the stimulus side.
  bit m_acq    = 1'b1;
  int m_good   = 0;
  bit m_locked = 1'b0;
  int cur_len  = 0;
  int cur_high = 0;

  task automatic check(input string tag, input int obs, input int expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_acq    = 1'b1;
    m_good   = 0;
    m_locked = 1'b0;
  endtask

  // Called as div_in is driven high: predicts what the DUT reports for this rise.
  task automatic model_rise();
    exp_t e;
    bit   match;
    if (cur_len > TIMEOUT) model_reset();
    e.chk    = 1'b0;
    e.err    = 1'b0;
    e.period = cur_len;
    e.high   = cur_high;
    if (m_acq) begin
      m_acq  = 1'b0;
      m_good = 0;
    end else begin
      e.chk = 1'b1;
      match = (cur_len == int'(exp_period)) && (exp_period >= 2);
      if (!match) begin
        e.err    = 1'b1;
        m_good   = 0;
        m_locked = 1'b0;
      end else if (!m_locked) begin
        m_good++;
        if (m_good == LOCK_COUNT) m_locked = 1'b1;
      end
    end
    e.lock = m_locked;
    sb.push_back(e);
  endtask

  // One period of div_in; drop >= 0 pulls enable low for one cycle in the low phase.
  task automatic drive_period(input int high, input int low, input int drop = -1);
    model_rise();
    cur_len  = high + low;
    cur_high = high;
    div_in   = 1'b1;
    repeat (high) begin
      @(posedge clk);
      #1;
    end
    div_in = 1'b0;
    for (int i = 0; i < low; i++) begin
      if (i == drop) begin
        enable = 1'b0;
        model_reset();
      end
      @(posedge clk);
      #1;
      enable = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
    cur_len += n;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 20) begin
      @(posedge clk);
      #1;
      k++;
    end
    cur_len += k;
    check("sb_drain", sb.size(), 0);
  endtask

  always @(negedge clk) begin
    if (rise_pulse) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        if (mon_e.chk) begin
          check("period_meas", int'(period_meas), mon_e.period);
          check("high_meas", int'(high_meas), mon_e.high);
        end
        check("err_period", int'(err_period), int'(mon_e.err));
        check("locked", int'(locked), int'(mon_e.lock));
      end
    end else if (err_period) begin
      check("err_without_rise", 1, 0);
    end
    if (err_period) err_cnt++;
    if (err_stuck) stuck_cnt++;
  end

  initial begin
    reset      = 1'b0;
    enable     = 1'b0;
    div_in     = 1'b0;
    exp_period = 8'd3;

    // Reset held while div_in toggles: everything stays at zero.
    for (int i = 0; i < 8; i++) begin
      div_in = i[0];
      @(negedge clk);
      check("reset_outputs", int'({period_meas, high_meas, rise_pulse, locked, err_period, err_stuck}), 0);
    end
    @(posedge clk);
    #1;
    reset   = 1'b1;
    enable  = 1'b1;
    div_in  = 1'b0;
    cur_len = 0;
    model_reset();

    // clk_3 pattern: high 1, low 2.
    repeat (6) drive_period(1, 2);
    check("lock_clk3", int'(locked), 1);
    drain();
    check("period_clk3", int'(period_meas), 3);
    check("high_clk3", int'(high_meas), 1);

    // Restart and lock on a 2-high 1-low pattern.
    enable = 1'b0;
    model_reset();
    idle(2);
    enable = 1'b1;
    idle(1);
    check("unlocked_after_enable", int'(locked), 0);
    repeat (6) drive_period(2, 1);
    check("lock_clk3_50", int'(locked), 1);
    check("high_clk3_50", int'(high_meas), 2);

    // One long period while locked, then re-lock.
    drive_period(1, 3);
    repeat (5) drive_period(1, 2);
    check("relock_after_mismatch", int'(locked), 1);
    check("err_count_mismatch", err_cnt, 1);

    // div_in stuck low, then stuck high.
    drive_period(1, 399);
    check("stuck_low_once", stuck_cnt, 1);
    check("stuck_low_unlock", int'(locked), 0);
    repeat (6) drive_period(1, 2);
    check("relock_after_stuck_low", int'(locked), 1);
    drive_period(400, 2);
    check("stuck_high_once", stuck_cnt, 2);
    repeat (6) drive_period(1, 2);
    check("relock_after_stuck_high", int'(locked), 1);

    // An expected period of 0 never matches.
    exp_period = 8'd0;
    repeat (2) drive_period(1, 2);
    check("exp0_unlock", int'(locked), 0);
    exp_period = 8'd3;
    repeat (4) drive_period(1, 2);
    check("relock_after_exp0", int'(locked), 1);

    // Enable drop in MEASURE.
    drive_period(1, 3);
    repeat (2) drive_period(1, 2);
    drive_period(1, 6, 3);
    repeat (4) drive_period(1, 2);
    check("no_lock_after_drop", int'(locked), 0);
    drive_period(1, 2);
    check("lock_after_drop", int'(locked), 1);
    check("err_count_total", err_cnt, 4);

    // Asynchronous reset mid-operation.
    drain();
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("async_reset_outputs", int'({period_meas, high_meas, rise_pulse, locked, err_period, err_stuck}), 0);
    @(posedge clk);
    #1;
    reset   = 1'b1;
    cur_len = 0;
    model_reset();
    repeat (6) drive_period(2, 1);
    check("lock_after_reset", int'(locked), 1);
    drain();
    check("stuck_total", stuck_cnt, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
